// File: rtl/insq_fifo_if.sv
// Instruction-queue bus: fetch push side, issue pop side, status back to fetch.
//
// Handshakes:
//   push: fetch offers an entry with push_valid; it is taken at the clock edge
//         if there is room (or the head leaves the same cycle). Fetch throttles
//         itself on insq_full, which asserts early so registered pushes still fit.
//   pop:  out_valid/out_ins/out_pc present the oldest entry (first-word-fall-
//         through); the entry is consumed at the edge where out_valid and
//         pop_ready are both high.
interface insq_fifo_if #(
  parameter int DEPTH_LOG = 4,
  parameter int INS_W     = 32,
  parameter int PC_W      = 32
);
  logic                 push_valid;
  logic [INS_W-1:0]     push_ins;
  logic [PC_W-1:0]      push_pc;
  logic                 insq_full;
  logic                 pop_ready;
  logic                 out_valid;
  logic [INS_W-1:0]     out_ins;
  logic [PC_W-1:0]      out_pc;
  logic [DEPTH_LOG:0]   count;

  // Pipeline side: fetch pushes, issue pops, both observe status.
  modport master (
    output push_valid, push_ins, push_pc, pop_ready,
    input  insq_full, out_valid, out_ins, out_pc, count
  );

  // Queue side.
  modport slave (
    input  push_valid, push_ins, push_pc, pop_ready,
    output insq_full, out_valid, out_ins, out_pc, count
  );
endinterface

// File: rtl/insq_fifo.sv
// Instruction queue between fetch and decode/issue.
// Circular buffer of 2**DEPTH_LOG (instruction, PC) pairs, FWFT head output,
// early-full to fetch, whole-queue flush on redirect, global ready stall.
// Optional: define INSQ_BYPASS_EN to forward a push straight to the output
// when the queue is empty (zero-latency push -> out_valid).
module insq_fifo #(
  parameter int DEPTH_LOG   = 4,
  parameter int INS_W       = 32,
  parameter int PC_W        = 32,
  parameter int FULL_MARGIN = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  input  logic          flush,
  insq_fifo_if.slave    q
);
  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] DEPTH_C   = (DEPTH_LOG+1)'(DEPTH);
  localparam logic [DEPTH_LOG:0] FULL_TH_C = (DEPTH_LOG+1)'(DEPTH - FULL_MARGIN);

  logic [INS_W-1:0]     mem_ins [DEPTH];
  logic [PC_W-1:0]      mem_pc  [DEPTH];
  logic [DEPTH_LOG-1:0] head;
  logic [DEPTH_LOG-1:0] tail;
  logic [DEPTH_LOG:0]   count_r;

  logic is_empty;
  logic is_full;
  logic live;        // this edge may change state at all
  logic bypass_act;  // empty queue forwarding the incoming push
  logic pop_acc;
  logic push_acc;
  logic do_write;    // push lands in the array
  logic do_adv;      // head pointer moves

  assign is_empty = (count_r == '0);
  assign is_full  = (count_r == DEPTH_C);
  assign live     = ready && !flush;

`ifdef INSQ_BYPASS_EN
  assign bypass_act = is_empty && q.push_valid && live;
`else
  assign bypass_act = 1'b0;
`endif

  // Pop and push acceptance; a full queue still takes a push if the head leaves.
  always_comb begin
    pop_acc  = live && q.pop_ready && q.out_valid;
    push_acc = live && q.push_valid && (!is_full || pop_acc);
    // A bypassed entry that is consumed immediately never touches the array.
    do_write = push_acc && !(bypass_act && pop_acc);
    do_adv   = pop_acc  && !bypass_act;
  end

  // Head presentation and status back to fetch.
  always_comb begin
    q.out_valid = !is_empty || bypass_act;
    q.out_ins   = bypass_act ? q.push_ins : mem_ins[head];
    q.out_pc    = bypass_act ? q.push_pc  : mem_pc[head];
    q.insq_full = (count_r >= FULL_TH_C);
    q.count     = count_r;
  end

  // Pointer and occupancy register; reset and flush empty the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count_r <= '0;
    end else if (ready) begin
      if (flush) begin
        head    <= '0;
        tail    <= '0;
        count_r <= '0;
      end else begin
        if (do_write) tail <= tail + 1'b1;
        if (do_adv)   head <= head + 1'b1;
        if (push_acc && !pop_acc)      count_r <= count_r + 1'b1;
        else if (pop_acc && !push_acc) count_r <= count_r - 1'b1;
      end
    end
  end

  // Entry storage; contents after reset/flush are don't-care.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_ins[tail] <= q.push_ins;
      mem_pc[tail]  <= q.push_pc;
    end
  end
endmodule

// File: tb/tb_insq_fifo.sv
// Self-checking bench for insq_fifo: vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
// Honours INSQ_BYPASS_EN when the build defines it.
module tb_insq_fifo;
  localparam int DEPTH_LOG   = 4;
  localparam int INS_W       = 32;
  localparam int PC_W        = 32;
  localparam int FULL_MARGIN = 2;
  localparam int DEPTH       = 16;

  logic clk = 1'b0;
  logic reset;
  logic ready;
  logic flush;

  insq_fifo_if #(.DEPTH_LOG(DEPTH_LOG), .INS_W(INS_W), .PC_W(PC_W)) bus();

  insq_fifo #(
    .DEPTH_LOG(DEPTH_LOG), .INS_W(INS_W), .PC_W(PC_W), .FULL_MARGIN(FULL_MARGIN)
  ) dut (
    .clk(clk), .reset(reset), .ready(ready), .flush(flush), .q(bus)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  logic [63:0] exp_q[$];  // scoreboard: {ins, pc}, oldest at index 0

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return pc ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic r, input logic rdy, input logic fl, input logic pv,
                       input logic [31:0] ins, input logic [31:0] pc, input logic pr);
    reset = r; ready = rdy; flush = fl;
    bus.push_valid = pv; bus.push_ins = ins; bus.push_pc = pc; bus.pop_ready = pr;
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    idle();
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    drive(1'b0, 1'b1, 1'b0, 1'b1, ins_of(pc), pc, 1'b0);
    tick();
    idle();
    #1;
  endtask

  task automatic pop_one();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    idle();
    #1;
  endtask

  // Checks occupancy, valid, full and (when valid) the head entry.
  task automatic chk_state(input string tag, input int cnt, input logic v,
                           input logic f, input logic [31:0] pc);
    chk({tag, ".count"}, 32'(bus.count), cnt);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, ".insq_full"}, 32'(bus.insq_full), 32'(f));
    if (v) begin
      chk({tag, ".out_pc"}, bus.out_pc, pc);
      chk({tag, ".out_ins"}, bus.out_ins, ins_of(pc));
    end
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        fl;
    logic        pv;
    logic [31:0] pc;
    logic        pr;
    int          e_cnt;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_full;
  } vec_t;

  vec_t tbl[12];

  // Random-run model variables
  logic        r_rst, r_rdy, r_fl, r_pv, r_pr;
  logic [31:0] r_ins, r_pc;
  int          sz;
  logic        m_byp, m_valid, m_pop, m_push;
  logic [63:0] m_head;
  logic [31:0] nxt_pop, nxt_push;

  initial begin
    idle();
    reset = 1'b1;

    // Table: inputs for one edge, then state seen with idle inputs afterwards.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 0, 1'b0, 32'h00, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 1, 1'b1, 32'h00, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h04, 1'b0, 2, 1'b1, 32'h00, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 1, 1'b1, 32'h04, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h08, 1'b1, 1, 1'b1, 32'h08, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 0, 1'b0, 32'h00, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 0, 1'b0, 32'h00, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 0, 1'b0, 32'h00, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h14, 1'b0, 1, 1'b1, 32'h14, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 0, 1'b0, 32'h00, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h1c, 1'b0, 1, 1'b1, 32'h1c, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 1'b1, 0, 1'b0, 32'h00, 1'b0};

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].rst, tbl[i].rdy, tbl[i].fl, tbl[i].pv, ins_of(tbl[i].pc),
            tbl[i].pc, tbl[i].pr);
      tick();
      idle();
      #1;
      chk_state($sformatf("tbl%0d", i), tbl[i].e_cnt, tbl[i].e_valid,
                tbl[i].e_full, tbl[i].e_pc);
    end

    // First push: same-cycle visibility only with bypass.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b1, ins_of(32'h0), 32'h0, 1'b0);
    #1;
`ifdef INSQ_BYPASS_EN
    chk("first.same_cycle_valid", 32'(bus.out_valid), 32'd1);
    chk("first.same_cycle_ins", bus.out_ins, 32'h0000_0013);
`else
    chk("first.same_cycle_valid", 32'(bus.out_valid), 32'd0);
`endif
    tick();
    idle();
    #1;
    chk_state("first", 1, 1'b1, 1'b0, 32'h0);
    chk("first.ins", bus.out_ins, 32'h0000_0013);

    // Push and pop together on an empty queue.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b1, ins_of(32'h40), 32'h40, 1'b1);
    tick();
    idle();
    #1;
`ifdef INSQ_BYPASS_EN
    chk_state("empty_pushpop", 0, 1'b0, 1'b0, 32'h0);
`else
    chk_state("empty_pushpop", 1, 1'b1, 1'b0, 32'h40);
`endif

    // Fill to early-full, then to full, then overflow attempt.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      push(32'(i * 4));
      chk_state($sformatf("fill%0d", i), i + 1, 1'b1, (i + 1) >= 14, 32'h0);
    end
    push(32'd56);
    push(32'd60);
    chk_state("full16", 16, 1'b1, 1'b1, 32'h0);
    push(32'd64);
    chk_state("overflow", 16, 1'b1, 1'b1, 32'h0);

    // Simultaneous push+pop at full for 20 cycles; pointers wrap.
    nxt_pop  = 32'd0;
    nxt_push = 32'd64;
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, ins_of(nxt_push), nxt_push, 1'b1);
      #1;
      chk($sformatf("wrap%0d.out_pc", k), bus.out_pc, nxt_pop);
      chk($sformatf("wrap%0d.count", k), 32'(bus.count), 32'd16);
      tick();
      nxt_pop  = nxt_pop + 32'd4;
      nxt_push = nxt_push + 32'd4;
    end
    idle();
    #1;
    chk("wrap_end.count", 32'(bus.count), 32'd16);
    // Drain: order must continue by +4 without loss or duplicate.
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d.out_pc", k), bus.out_pc, nxt_pop);
      pop_one();
      nxt_pop = nxt_pop + 32'd4;
    end
    chk_state("drained", 0, 1'b0, 1'b0, 32'h0);

    // Flush with concurrent push and pop.
    do_reset();
    for (int i = 0; i < 5; i++) push(32'h200 + 32'(i * 4));
    drive(1'b0, 1'b1, 1'b1, 1'b1, ins_of(32'h300), 32'h300, 1'b1);
    tick();
    idle();
    #1;
    chk_state("flush", 0, 1'b0, 1'b0, 32'h0);
    push(32'h400);
    chk_state("after_flush", 1, 1'b1, 1'b0, 32'h400);

    // Global stall holds all state.
    do_reset();
    push(32'h100);
    push(32'h104);
    push(32'h108);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, ins_of(32'h500), 32'h500, 1'b1);
      tick();
      chk_state($sformatf("stall%0d", k), 3, 1'b1, 1'b0, 32'h100);
    end
    idle();
    pop_one();
    chk_state("resume", 2, 1'b1, 1'b0, 32'h104);

    // Underflow: popping an empty queue changes nothing.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      tick();
      chk_state($sformatf("underflow%0d", k), 0, 1'b0, 1'b0, 32'h0);
    end

    // Randomized run against the queue model.
    do_reset();
    exp_q.delete();
    for (int c = 0; c < 3000; c++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      r_rdy = ($urandom_range(0, 9) != 0);
      r_fl  = ($urandom_range(0, 39) == 0);
      r_pv  = ($urandom_range(0, 99) < 60);
      r_pr  = ((c % 600) < 300) ? ($urandom_range(0, 99) < 30)
                                : ($urandom_range(0, 99) < 75);
      r_ins = $urandom;
      r_pc  = $urandom;
      drive(r_rst, r_rdy, r_fl, r_pv, r_ins, r_pc, r_pr);
      #1;

      sz = exp_q.size();
`ifdef INSQ_BYPASS_EN
      m_byp = (sz == 0) && r_pv && r_rdy && !r_fl;
`else
      m_byp = 1'b0;
`endif
      m_valid = (sz != 0) || m_byp;
      m_head  = m_byp ? {r_ins, r_pc} : ((sz != 0) ? exp_q[0] : 64'h0);

      chk("rnd.count", 32'(bus.count), 32'(sz));
      chk("rnd.out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("rnd.insq_full", 32'(bus.insq_full), 32'(sz >= DEPTH - FULL_MARGIN));
      if (m_valid) begin
        chk("rnd.out_ins", bus.out_ins, m_head[63:32]);
        chk("rnd.out_pc", bus.out_pc, m_head[31:0]);
      end

      if (r_rst) begin
        exp_q.delete();
      end else if (r_rdy && r_fl) begin
        exp_q.delete();
      end else if (r_rdy) begin
        m_pop  = r_pr && m_valid;
        m_push = r_pv && ((sz < DEPTH) || m_pop);
        if (!(m_byp && m_pop)) begin
          if (m_pop) void'(exp_q.pop_front());
          if (m_push) exp_q.push_back({r_ins, r_pc});
        end
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule

// File: doc/insq_fifo.md
Name: insq_fifo

Overview:
- Instruction queue between the fetch stage and the decode/issue stage.
- Buffers (instruction, PC) pairs pushed by fetch and presents the oldest entry to issue with a valid/ready handshake (first-word-fall-through).
- Drives the early-full signal that fetch uses to stop pushing.
- Flushes all entries on a branch/jump redirect.

Parameters:
- DEPTH_LOG, 4, log2 of entry count (DEPTH = 16).
- INS_W, 32, instruction word width.
- PC_W, 32, PC width.
- FULL_MARGIN, 2, free slots reserved before insq_full asserts; covers fetch's registered push latency.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- ready  in  1  global enable; low = hold all state
- push_valid  in  1  fetch has an entry this cycle
- push_ins  in  INS_W  instruction from fetch
- push_pc  in  PC_W  PC of push_ins
- insq_full  out  1  early-full indication to fetch
- flush  in  1  jump/mispredict redirect; discard all entries
- pop_ready  in  1  issue consumes head this cycle if out_valid
- out_valid  out  1  head entry valid
- out_ins  out  INS_W  head instruction
- out_pc  out  PC_W  head PC
- count  out  DEPTH_LOG+1  current occupancy

Behaviour:
- Storage:
  - Circular buffer of DEPTH entries with head/tail pointers of DEPTH_LOG bits that wrap modulo DEPTH.
  - count is a separate register, range 0..DEPTH.
- Reset (synchronous, highest priority):
  - head=tail=0, count=0, so out_valid=0 and insq_full=0.
  - Array contents are don't-care.
  - Reset mid-operation discards everything immediately.
- ready=0: no state changes. Outputs hold their combinational values from current state; pop/push that cycle are ignored.
- flush=1 (with ready=1):
  - head=tail=0, count=0 at the edge.
  - Any push/pop in the same cycle is discarded.
  - out_valid=0 the following cycle.
- Push (accepted at clk edge) when push_valid=1 and count<DEPTH, or when count==DEPTH and a pop is accepted in the same cycle.
  - Effect: entry[tail]<=push, tail<=tail+1.
- Pop (accepted at clk edge) when pop_ready=1 and out_valid=1.
  - Effect: head<=head+1.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Overflow: push_valid with count==DEPTH and no pop → entry dropped, pointers and count unchanged.
  - This is a protocol violation by fetch and must not occur when FULL_MARGIN is honoured.
- Underflow: pop_ready with count==0 → ignored.
- out_valid = (count!=0).
  - out_ins/out_pc = entry[head], combinational (FWFT).
  - An entry pushed at edge N is visible at out_* after edge N (1-cycle latency when not bypassing).
- insq_full = (count >= DEPTH-FULL_MARGIN), combinational from count.
  - Fetch samples it at the edge and pushes one cycle later. With margin 2, at most 2 pushes arrive after assertion, so no overflow.
- Pointer wrap: tail/head 15→0 with DEPTH=16; count distinguishes full from empty when head==tail.

Optional Feature:
- Macro INSQ_BYPASS_EN.
- Defined:
  - When count==0 and push_valid=1 (and flush=0, ready=1), out_valid=1 and out_ins/out_pc = push_ins/push_pc combinationally in the same cycle.
  - If pop_ready=1 in that cycle, the entry is consumed and not written: tail and count unchanged.
  - If pop_ready=0, the entry is written normally.
- Undefined:
  - out_valid depends only on count.
  - Minimum push→out_valid latency is 1 cycle.

Test Plan:
- Reset, then push ins=0x00000013 pc=0x0 → out_valid=1, out_ins=0x00000013, out_pc=0x0 the next cycle (same cycle under INSQ_BYPASS_EN); count=1.
- 14 pushes with pop_ready=0 → insq_full=1 once count=14. Two further pushes accepted (count=16). A 17th push with no pop is dropped; count stays 16 and the head is still the first entry.
- Fill to 16, then push and pop in the same cycle for 20 cycles (pointers wrap) → count stays 16; popped PCs strictly increase by 4 in order with no loss or duplicate.
- count=5, flush=1 together with push_valid=1 and pop_ready=1 → next cycle count=0, out_valid=0, insq_full=0, and the pushed entry is absent.
- count=3, ready=0 for 4 cycles with push_valid=1 and pop_ready=1 → count stays 3 and out_pc is unchanged. After ready returns to 1, normal operation resumes.
- count=0, pop_ready=1 for 3 cycles → no state change, out_valid=0, count=0.
